mfp_adc_max10_averager: RTL and testbench
=========================================

// Module: mfp_adc_max10_averager
// PURPOSE
//  Per-channel oversampling averager on the MAX10 ADC response stream.
//  Sits between the Altera ADC IP response port and the ADC controller core's ADC_R_* inputs.
//  Accumulates 2**LOG2_AVG samples per channel and emits one averaged response beat per full window.
//  Channels at or above NUM_CH, or all traffic while AVG_Enable=0, pass through with 1-cycle latency.
// PARAMETERS
//  LOG2_AVG  2   log2 of samples per window (0..6); 0 = pure registered pass-through
//  NUM_CH    18  channels 0..NUM_CH-1 are averaged; higher channel numbers pass through
// PORTS
//  CLK          in   1   system clock; sole clock of the block
//  RESET        in   1   synchronous reset, active-high
//  AVG_Enable   in   1   1 = averaging on, 0 = pass-through with accumulators held cleared
//  AVG_Clear    in   1   single-cycle pulse that discards all partial windows
//  IN_Valid     in   1   ADC IP response valid (no backpressure exists on this stream)
//  IN_Channel   in   5   response channel
//  IN_Data      in   12  response sample
//  IN_SOP       in   1   response startofpacket
//  IN_EOP       in   1   response endofpacket
//  OUT_Valid    out  1   averaged or passed-through response valid; drives core ADC_R_Valid
//  OUT_Channel  out  5   channel of the output beat
//  OUT_Data     out  12  averaged or raw sample
//  OUT_SOP      out  1   startofpacket of the output beat
//  OUT_EOP      out  1   endofpacket of the output beat
// BEHAVIOUR
//  - One clock (CLK); reset is synchronous and active-high (RESET). All outputs are registered.
//  - RESET: all OUT_* = 0; every acc[ch] and cnt[ch] = 0. Reset mid-window discards partial sums.
//  - State per channel ch < NUM_CH:
//    - acc[ch]: width 12+LOG2_AVG; cannot overflow because 2**LOG2_AVG * 4095 fits.
//    - cnt[ch]: width LOG2_AVG, counts samples in the open window.
//  - Averaged path: IN_Valid=1, AVG_Enable=1, IN_Channel < NUM_CH, LOG2_AVG > 0.
//    - If cnt[ch] != 2**LOG2_AVG-1:
//      - acc[ch] += IN_Data; cnt[ch]++.
//      - OUT_Valid=0 on the next cycle.
//    - Else (window completes):
//      - Next cycle: OUT_Valid=1; OUT_Data=(acc[ch]+IN_Data)>>LOG2_AVG (truncating); OUT_Channel=ch.
//      - OUT_SOP/OUT_EOP are copied from the completing beat.
//      - acc[ch]=0; cnt[ch]=0.
//  - Pass-through path: any other IN_Valid beat.
//    - IN_* is registered to OUT_* unchanged; latency 1 cycle.
//    - The beat does not touch any accumulator.
//  - OUT_Valid is a single-cycle pulse per emitted beat. OUT_Channel/Data/SOP/EOP are held between beats.
//  - No input beat is ever dropped or stalled; the block accepts one beat per cycle, back-to-back.
//  - Channels are independent: interleaving samples of different channels does not disturb other windows.
//  - AVG_Enable=0: all acc/cnt are forced to 0 every cycle, and every beat takes the pass-through path.
//    - Re-enabling starts fresh windows.
//  - AVG_Clear=1: all acc/cnt are cleared first.
//    - A same-cycle IN_Valid averaged beat is then applied to the cleared channel: acc=IN_Data, cnt=1.
//    - No output is produced for that beat unless LOG2_AVG=0.
//  - RESET overrides AVG_Clear, AVG_Enable and IN_Valid.
//  - LOG2_AVG=0: every beat is emitted 1 cycle later with data unchanged.
// TESTING
//  - LOG2_AVG=2, ch3 samples 100,200,300,401 -> exactly one OUT_Valid, 1 cycle after 4th beat: OUT_Channel=3, OUT_Data=250.
//  - Interleave ch0 {8,8,8,8} with ch1 {0,4,8,12} back-to-back -> ch0 output 8 and ch1 output 6; each appears 1 cycle after its 4th sample.
//  - Four samples of 4095 on ch17 -> OUT_Data=4095; no wrap.
//  - ch31 data 0xABC with SOP=EOP=1 -> next cycle OUT_Valid=1, OUT_Channel=31, OUT_Data=0xABC, SOP=EOP=1.
//  - ch2 samples 10,20, then AVG_Clear together with sample 30 -> no output; ch2 samples 40,50,60 -> output 45.
//  - RESET after 2 samples of ch5 -> outputs 0; 4 new samples of 7 -> output 7.
//  - AVG_Enable=0 -> every beat is mirrored 1 cycle later.

Source files
------------

// File: rtl/mfp_adc_max10_averager.sv
// Per-channel oversampling averager for the MAX10 ADC response stream.
// Sums 2**LOG2_AVG samples per channel and emits one truncated average per
// completed window. Beats on channels >= NUM_CH, and all beats while
// averaging is disabled, are registered straight through (1-cycle latency).
// Ports:
//   CLK, RESET                         clock, synchronous active-high reset
//   AVG_Enable                         1 = average, 0 = pass-through
//   AVG_Clear                          pulse: drop every partial window
//   IN_Valid/Channel/Data/SOP/EOP      ADC IP response beat (no backpressure)
//   OUT_Valid/Channel/Data/SOP/EOP     registered response beat to the core
module mfp_adc_max10_averager #(
  parameter int unsigned LOG2_AVG = 2,
  parameter int unsigned NUM_CH   = 18
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AVG_Enable,
  input  logic        AVG_Clear,
  input  logic        IN_Valid,
  input  logic [4:0]  IN_Channel,
  input  logic [11:0] IN_Data,
  input  logic        IN_SOP,
  input  logic        IN_EOP,
  output logic        OUT_Valid,
  output logic [4:0]  OUT_Channel,
  output logic [11:0] OUT_Data,
  output logic        OUT_SOP,
  output logic        OUT_EOP
);

  localparam int unsigned DW = 12;
  localparam int unsigned AW = DW + LOG2_AVG;
  // Keep the counter at least one bit wide so LOG2_AVG=0 stays legal.
  localparam int unsigned CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

  logic [AW-1:0] acc [NUM_CH];
  logic [CW-1:0] cnt [NUM_CH];

  logic          avg_beat_c;
  logic [AW-1:0] sel_acc_c;
  logic [CW-1:0] sel_cnt_c;
  logic [AW-1:0] sum_c;
  logic          complete_c;

  // Window state of the addressed channel, as seen after any same-cycle clear.
  always_comb begin
    sel_acc_c = '0;
    sel_cnt_c = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (IN_Channel == 5'(c)) begin
        sel_acc_c = acc[c];
        sel_cnt_c = cnt[c];
      end
    end
    if (AVG_Clear) begin
      sel_acc_c = '0;
      sel_cnt_c = '0;
    end
    avg_beat_c = IN_Valid && AVG_Enable && (LOG2_AVG > 0) &&
                 (32'(IN_Channel) < 32'(NUM_CH));
    sum_c      = sel_acc_c + AW'(IN_Data);
    complete_c = (sel_cnt_c == CNT_LAST);
  end

  // Accumulators, counters and the registered output beat.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_Valid   <= 1'b0;
      OUT_Channel <= '0;
      OUT_Data    <= '0;
      OUT_SOP     <= 1'b0;
      OUT_EOP     <= 1'b0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      OUT_Valid <= 1'b0;
      // Disable holds windows cleared; clear drops them before the beat lands.
      if (!AVG_Enable || AVG_Clear) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end
      end
      if (avg_beat_c) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (IN_Channel == 5'(c)) begin
            if (complete_c) begin
              acc[c] <= '0;
              cnt[c] <= '0;
            end else begin
              acc[c] <= sum_c;
              cnt[c] <= sel_cnt_c + CW'(1);
            end
          end
        end
        if (complete_c) begin
          OUT_Valid   <= 1'b1;
          OUT_Channel <= IN_Channel;
          OUT_Data    <= DW'(sum_c >> LOG2_AVG);
          OUT_SOP     <= IN_SOP;
          OUT_EOP     <= IN_EOP;
        end
      end else if (IN_Valid) begin
        OUT_Valid   <= 1'b1;
        OUT_Channel <= IN_Channel;
        OUT_Data    <= IN_Data;
        OUT_SOP     <= IN_SOP;
        OUT_EOP     <= IN_EOP;
      end
    end
  end

endmodule

// File: tb/tb_mfp_adc_max10_averager.sv
// Directed-vector bench for mfp_adc_max10_averager (LOG2_AVG=2, NUM_CH=18).
// Each table row drives one cycle of inputs and gives the outputs expected
// just after the following rising edge.
module tb_mfp_adc_max10_averager;

  logic        clk = 1'b0;
  logic        rst, en, clr, vld, sop, eop;
  logic [4:0]  ch;
  logic [11:0] dat;
  logic        o_vld, o_sop, o_eop;
  logic [4:0]  o_ch;
  logic [11:0] o_dat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mfp_adc_max10_averager #(.LOG2_AVG(2), .NUM_CH(18)) dut (
    .CLK(clk), .RESET(rst), .AVG_Enable(en), .AVG_Clear(clr),
    .IN_Valid(vld), .IN_Channel(ch), .IN_Data(dat), .IN_SOP(sop), .IN_EOP(eop),
    .OUT_Valid(o_vld), .OUT_Channel(o_ch), .OUT_Data(o_dat),
    .OUT_SOP(o_sop), .OUT_EOP(o_eop)
  );

  typedef struct {
    logic        rst, en, clr, vld;
    logic [4:0]  ch;
    logic [11:0] dat;
    logic        sop, eop;
    logic [19:0] exp;   // {valid, channel, data, sop, eop}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int r, int e, int c, int v, int ich, int idat, int is, int ie,
                              int ev, int ech, int edat, int es, int ee);
    vec_t t;
    t.rst = 1'(r); t.en = 1'(e); t.clr = 1'(c); t.vld = 1'(v);
    t.ch = 5'(ich); t.dat = 12'(idat); t.sop = 1'(is); t.eop = 1'(ie);
    t.exp = {1'(ev), 5'(ech), 12'(edat), 1'(es), 1'(ee)};
    return t;
  endfunction

  task automatic check(string name, logic [19:0] got, logic [19:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got v=%0b ch=%0d d=%0d sop=%0b eop=%0b, want v=%0b ch=%0d d=%0d sop=%0b eop=%0b",
               name, got[19], got[18:14], got[13:2], got[1], got[0],
               want[19], want[18:14], want[13:2], want[1], want[0]);
    end
  endtask

  task automatic drive(logic r, logic e, logic c, logic v, logic [4:0] ich,
                       logic [11:0] idat, logic is, logic ie);
    rst = r; en = e; clr = c; vld = v; ch = ich; dat = idat; sop = is; eop = ie;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b0;
    ch = '0; dat = '0; sop = 1'b0; eop = 1'b0;

    //                r e c v ch  dat  s e   ev ech edat es ee
    vecs.push_back(mk(1,0,0,0, 0,   0, 0,0,  0, 0,   0, 0,0));
    // ch3 100,200,300,401 -> 250
    vecs.push_back(mk(0,1,0,1, 3, 100, 0,0,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 3, 200, 0,0,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 3, 300, 0,0,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 3, 401, 0,1,  1, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,0, 0,   0, 0,0,  0, 3, 250, 0,1));
    // interleaved ch0 {8,8,8,8} / ch1 {0,4,8,12}
    vecs.push_back(mk(0,1,0,1, 0,   8, 0,0,  0, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,1, 1,   0, 0,0,  0, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,1, 0,   8, 0,0,  0, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,1, 1,   4, 0,0,  0, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,1, 0,   8, 0,0,  0, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,1, 1,   8, 0,0,  0, 3, 250, 0,1));
    vecs.push_back(mk(0,1,0,1, 0,   8, 0,0,  1, 0,   8, 0,0));
    vecs.push_back(mk(0,1,0,1, 1,  12, 0,0,  1, 1,   6, 0,0));
    // full-scale on ch17
    vecs.push_back(mk(0,1,0,1,17,4095, 0,0,  0, 1,   6, 0,0));
    vecs.push_back(mk(0,1,0,1,17,4095, 0,0,  0, 1,   6, 0,0));
    vecs.push_back(mk(0,1,0,1,17,4095, 0,0,  0, 1,   6, 0,0));
    vecs.push_back(mk(0,1,0,1,17,4095, 0,0,  1,17,4095, 0,0));
    // ch31 pass-through
    vecs.push_back(mk(0,1,0,1,31,'hABC,1,1,  1,31,'hABC,1,1));
    vecs.push_back(mk(0,1,0,0, 0,   0, 0,0,  0,31,'hABC,1,1));
    // clear with same-cycle sample on ch2 -> 45
    vecs.push_back(mk(0,1,0,1, 2,  10, 0,0,  0,31,'hABC,1,1));
    vecs.push_back(mk(0,1,0,1, 2,  20, 0,0,  0,31,'hABC,1,1));
    vecs.push_back(mk(0,1,1,1, 2,  30, 0,0,  0,31,'hABC,1,1));
    vecs.push_back(mk(0,1,0,1, 2,  40, 0,0,  0,31,'hABC,1,1));
    vecs.push_back(mk(0,1,0,1, 2,  50, 0,0,  0,31,'hABC,1,1));
    vecs.push_back(mk(0,1,0,1, 2,  60, 1,0,  1, 2,  45, 1,0));
    // reset mid-window on ch5 (with a beat that must be ignored)
    vecs.push_back(mk(0,1,0,1, 5,1000, 0,0,  0, 2,  45, 1,0));
    vecs.push_back(mk(0,1,0,1, 5,1000, 0,0,  0, 2,  45, 1,0));
    vecs.push_back(mk(1,1,0,1, 5, 999, 1,1,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 5,   7, 0,0,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 5,   7, 0,0,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 5,   7, 0,0,  0, 0,   0, 0,0));
    vecs.push_back(mk(0,1,0,1, 5,   7, 0,1,  1, 5,   7, 0,1));
    // partial ch4 window, then disable mirrors beats and wipes the window
    vecs.push_back(mk(0,1,0,1, 4,1000, 0,0,  0, 5,   7, 0,1));
    vecs.push_back(mk(0,0,0,1, 3, 123, 1,0,  1, 3, 123, 1,0));
    vecs.push_back(mk(0,0,0,1, 0,'hFFF,0,1,  1, 0,'hFFF,0,1));
    vecs.push_back(mk(0,0,0,0, 0,   0, 0,0,  0, 0,'hFFF,0,1));
    vecs.push_back(mk(0,1,0,1, 4,   4, 0,0,  0, 0,'hFFF,0,1));
    vecs.push_back(mk(0,1,0,1, 4,   4, 0,0,  0, 0,'hFFF,0,1));
    vecs.push_back(mk(0,1,0,1, 4,   4, 0,0,  0, 0,'hFFF,0,1));
    vecs.push_back(mk(0,1,0,1, 4,   4, 0,0,  1, 4,   4, 0,0));
    // first channels above NUM_CH pass through back-to-back
    vecs.push_back(mk(0,1,0,1,18,   5, 0,0,  1,18,   5, 0,0));
    vecs.push_back(mk(0,1,0,1,20,   6, 1,0,  1,20,   6, 1,0));
    vecs.push_back(mk(0,1,0,0, 0,   0, 0,0,  0,20,   6, 1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].vld,
            vecs[i].ch, vecs[i].dat, vecs[i].sop, vecs[i].eop);
      check($sformatf("vec%0d", i), {o_vld, o_ch, o_dat, o_sop, o_eop}, vecs[i].exp);
    end

    // Stand-alone clear pulse drops a 3-sample ch6 window; fresh window of 20s follows.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 12'd100, 1'b0, 1'b0);
      check($sformatf("ch6_fill%0d", i), {o_vld, o_ch, o_dat, o_sop, o_eop},
            {1'b0, 5'd20, 12'd6, 1'b1, 1'b0});
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 12'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 12'd20, 1'b0, 1'b0);
      if (i < 3)
        check($sformatf("ch6_new%0d", i), {19'd0, o_vld}, 20'd0);
    end
    check("ch6_avg", {o_vld, o_ch, o_dat, o_sop, o_eop}, {1'b1, 5'd6, 12'd20, 1'b0, 1'b0});

    // Truncation and single-cycle pulse on ch7: 1+2+3+6=12 -> 3, then 1+1+1+2=5 -> 1.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd6, 1'b1, 1'b1);
    check("ch7_avg", {o_vld, o_ch, o_dat, o_sop, o_eop}, {1'b1, 5'd7, 12'd3, 1'b1, 1'b1});
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd1, 1'b0, 1'b0);
    check("ch7_pulse", {o_vld, o_ch, o_dat, o_sop, o_eop}, {1'b0, 5'd7, 12'd3, 1'b1, 1'b1});
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'd2, 1'b0, 1'b0);
    check("ch7_trunc", {o_vld, o_ch, o_dat, o_sop, o_eop}, {1'b1, 5'd7, 12'd1, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
